// File: rtl/par_to_ser_mch.sv
// Multi-channel DDR serializer: one parallel word per channel, shifted out
// LSB-first two bits per clk_5x cycle through a ddio_out pair per channel.

module par_to_ser_mch_ddio (
  input  logic outclock,
  input  logic datain_h,
  input  logic datain_l,
  output logic dataout
);

  logic h_q;
  logic l_q;

  // Both halves are captured on the outclock rising edge; high half is
  // driven while outclock is high, low half while it is low.
  always_ff @(posedge outclock) begin
    h_q <= datain_h;
    l_q <= datain_l;
  end

  assign dataout = outclock ? h_q : l_q;

endmodule

module par_to_ser_mch #(
  parameter int                CH_NUM  = 4,
  parameter int                DATA_W  = 10,
  parameter logic [DATA_W-1:0] TP_WORD = 10'b11111_00000
) (
  input  logic                     clk_5x,
  input  logic                     sys_rst_n,
  input  logic [CH_NUM*DATA_W-1:0] data_in,
  input  logic                     tp_en,
  input  logic [CH_NUM-1:0]        ch_en,
  input  logic [CH_NUM-1:0]        pol_inv,
  output logic                     load_stb,
  output logic [CH_NUM-1:0]        ser_p,
  output logic [CH_NUM-1:0]        ser_n
);

  localparam int RATIO = DATA_W / 2;
  localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(RATIO - 1);

  if (((DATA_W % 2) != 0) || (DATA_W < 4)) begin : g_bad_w
    $error("par_to_ser_mch: DATA_W must be even and >= 4");
  end

  logic [CW-1:0]                   cnt;
  logic [CH_NUM-1:0][DATA_W-1:0]   word;
  logic [CH_NUM-1:0][RATIO-1:0]    rise_d;
  logic [CH_NUM-1:0][RATIO-1:0]    fall_d;
  logic [CH_NUM-1:0][RATIO-1:0]    rise_s;
  logic [CH_NUM-1:0][RATIO-1:0]    fall_s;
  logic                            clk_n;

  assign load_stb = (cnt == CNT_MAX);

  // Source select, then polarity, then enable mask: the mask always wins.
  always_comb begin
    word = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      word[k] = tp_en ? TP_WORD : data_in[k*DATA_W +: DATA_W];
      if (pol_inv[k]) word[k] = ~word[k];
      if (!ch_en[k])  word[k] = '0;
    end
  end

  always_comb begin
    rise_d = '0;
    fall_d = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      for (int i = 0; i < RATIO; i++) begin
        rise_d[k][i] = word[k][2*i];
        fall_d[k][i] = word[k][2*i+1];
      end
    end
  end

  always_ff @(posedge clk_5x or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt    <= '0;
      rise_s <= '0;
      fall_s <= '0;
    end else begin
      cnt <= load_stb ? '0 : cnt + CW'(1);
      for (int k = 0; k < CH_NUM; k++) begin
        if (load_stb) begin
          rise_s[k] <= rise_d[k];
          fall_s[k] <= fall_d[k];
        end else begin
          rise_s[k] <= rise_s[k] >> 1;
          fall_s[k] <= fall_s[k] >> 1;
        end
      end
    end
  end

  assign clk_n = ~clk_5x;

  // Output registers have no reset; zeroed shifters flush them in one cycle.
  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    par_to_ser_mch_ddio u_ddio_p (
      .outclock (clk_n),
      .datain_h (rise_s[k][0]),
      .datain_l (fall_s[k][0]),
      .dataout  (ser_p[k])
    );

    par_to_ser_mch_ddio u_ddio_n (
      .outclock (clk_n),
      .datain_h (~rise_s[k][0]),
      .datain_l (~fall_s[k][0]),
      .dataout  (ser_n[k])
    );
  end

endmodule

// File: tb/tb_par_to_ser_mch.sv
// Directed bench for par_to_ser_mch: table of words plus reset,
// mid-word control, and 14-bit width sequences.

module tb_par_to_ser_mch;

  localparam int CH  = 4;
  localparam int DW  = 10;
  localparam int CH2 = 2;
  localparam int DW2 = 14;
  localparam logic [DW2-1:0] TP14 = 14'h3F80;

  localparam logic [CH*DW-1:0] DA = {10'h001, 10'h2AA, 10'h155, 10'h34E};
  localparam logic [CH*DW-1:0] DB = {10'h201, 10'h200, 10'h000, 10'h3FF};

  logic                 clk_5x = 1'b0;
  logic                 sys_rst_n;
  logic [CH*DW-1:0]     data_in;
  logic                 tp_en;
  logic [CH-1:0]        ch_en;
  logic [CH-1:0]        pol_inv;
  logic                 load_stb;
  logic [CH-1:0]        ser_p;
  logic [CH-1:0]        ser_n;

  logic [CH2*DW2-1:0]   data14;
  logic                 tp14;
  logic [CH2-1:0]       en14;
  logic [CH2-1:0]       pol14;
  logic                 stb14;
  logic [CH2-1:0]       p14;
  logic [CH2-1:0]       n14;

  int vecs   = 0;
  int miscmp = 0;

  logic [CH-1:0]  cp   [64];
  logic [CH-1:0]  cn   [64];
  logic [CH2-1:0] cp14 [64];
  logic [CH2-1:0] cn14 [64];

  typedef struct {
    logic [CH*DW-1:0] data;
    logic             tp;
    logic [CH-1:0]    en;
    logic [CH-1:0]    pol;
    logic [CH*DW-1:0] exp;
  } vec_t;

  vec_t tbl [7];

  always #5 clk_5x = ~clk_5x;

  par_to_ser_mch dut (
    .clk_5x    (clk_5x),
    .sys_rst_n (sys_rst_n),
    .data_in   (data_in),
    .tp_en     (tp_en),
    .ch_en     (ch_en),
    .pol_inv   (pol_inv),
    .load_stb  (load_stb),
    .ser_p     (ser_p),
    .ser_n     (ser_n)
  );

  par_to_ser_mch #(
    .CH_NUM  (CH2),
    .DATA_W  (DW2),
    .TP_WORD (TP14)
  ) dut14 (
    .clk_5x    (clk_5x),
    .sys_rst_n (sys_rst_n),
    .data_in   (data14),
    .tp_en     (tp14),
    .ch_en     (en14),
    .pol_inv   (pol14),
    .load_stb  (stb14),
    .ser_p     (p14),
    .ser_n     (n14)
  );

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      miscmp++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic sync_load(input bit w14);
    int  n;
    logic s;
    n = 0;
    do begin
      @(negedge clk_5x);
      n++;
      s = w14 ? stb14 : load_stb;
    end while (!s && n < 20);
    if (!s) begin
      vecs++;
      miscmp++;
      $display("FAIL sync_load w14=%0d load_stb=%b exp=1", w14, s);
    end
    @(posedge clk_5x);
  endtask

  task automatic cap(input int nb);
    for (int i = 0; i < nb / 2; i++) begin
      @(negedge clk_5x);
      #1;
      cp[2*i] = ser_p;
      cn[2*i] = ser_n;
      cp14[2*i] = p14;
      cn14[2*i] = n14;
      @(posedge clk_5x);
      #1;
      cp[2*i+1] = ser_p;
      cn[2*i+1] = ser_n;
      cp14[2*i+1] = p14;
      cn14[2*i+1] = n14;
    end
  endtask

  function automatic logic [DW-1:0] wp(input int k, input int w, input bit n);
    logic [DW-1:0] r;
    for (int i = 0; i < DW; i++) r[i] = n ? cn[w*DW+i][k] : cp[w*DW+i][k];
    return r;
  endfunction

  function automatic logic [DW2-1:0] wp14(input int k, input int w, input bit n);
    logic [DW2-1:0] r;
    for (int i = 0; i < DW2; i++) r[i] = n ? cn14[w*DW2+i][k] : cp14[w*DW2+i][k];
    return r;
  endfunction

  task automatic chk_word(input string tag, input int w,
                          input logic [CH*DW-1:0] exp);
    logic [DW-1:0] e;
    logic [DW-1:0] ne;
    for (int k = 0; k < CH; k++) begin
      e  = exp[k*DW +: DW];
      ne = ~e;
      chk($sformatf("%s w%0d ser_p ch%0d", tag, w, k), wp(k, w, 1'b0), e);
      chk($sformatf("%s w%0d ser_n ch%0d", tag, w, k), wp(k, w, 1'b1), ne);
    end
  endtask

  task automatic chk_word14(input string tag, input int w,
                            input logic [CH2*DW2-1:0] exp);
    logic [DW2-1:0] e;
    logic [DW2-1:0] ne;
    for (int k = 0; k < CH2; k++) begin
      e  = exp[k*DW2 +: DW2];
      ne = ~e;
      chk($sformatf("%s w%0d p14 ch%0d", tag, w, k), wp14(k, w, 1'b0), e);
      chk($sformatf("%s w%0d n14 ch%0d", tag, w, k), wp14(k, w, 1'b1), ne);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " load_stb"}, load_stb, 0);
    chk({tag, " ser_p"}, ser_p, 4'h0);
    chk({tag, " ser_n"}, ser_n, 4'hF);
  endtask

  // Release from mid-cycle; cycle 1 is the remainder with cnt = 0.
  task automatic release_check(input string tag, input int ncyc);
    sys_rst_n = 1'b1;
    chk($sformatf("%s stb c1", tag), load_stb, 0);
    for (int c = 2; c <= ncyc; c++) begin
      @(posedge clk_5x);
      #1;
      chk($sformatf("%s stb c%0d", tag, c), load_stb, (c % 5) == 0);
      chk($sformatf("%s stb14 c%0d", tag, c), stb14, (c % 7) == 0);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{data: DA, tp: 1'b0, en: 4'hF, pol: 4'h0, exp: DA};
    tbl[1] = '{data: DA, tp: 1'b1, en: 4'hF, pol: 4'h0,
               exp: {4{10'h3E0}}};
    tbl[2] = '{data: DA, tp: 1'b0, en: 4'hB, pol: 4'h1,
               exp: {10'h001, 10'h000, 10'h155, 10'h0B1}};
    tbl[3] = '{data: DA, tp: 1'b1, en: 4'hB, pol: 4'h4,
               exp: {10'h3E0, 10'h000, 10'h3E0, 10'h3E0}};
    tbl[4] = '{data: DA, tp: 1'b1, en: 4'hF, pol: 4'hF,
               exp: {4{10'h01F}}};
    tbl[5] = '{data: DB, tp: 1'b0, en: 4'hF, pol: 4'h2,
               exp: {10'h201, 10'h200, 10'h3FF, 10'h3FF}};
    tbl[6] = '{data: DB, tp: 1'b0, en: 4'h0, pol: 4'h0, exp: '0};

    sys_rst_n = 1'b0;
    data_in   = {$urandom, $urandom};
    tp_en     = 1'b0;
    ch_en     = 4'hF;
    pol_inv   = 4'h0;
    data14    = {$urandom};
    tp14      = 1'b0;
    en14      = 2'b11;
    pol14     = 2'b00;

    repeat (3) @(posedge clk_5x);
    @(negedge clk_5x);
    #1;
    chk_idle("rst");
    chk("rst stb14", stb14, 0);
    chk("rst p14", p14, 2'b00);
    chk("rst n14", n14, 2'b11);
    release_check("rel", 10);

    for (int v = 0; v < 7; v++) begin
      data_in = tbl[v].data;
      tp_en   = tbl[v].tp;
      ch_en   = tbl[v].en;
      pol_inv = tbl[v].pol;
      sync_load(1'b0);
      cap(2 * DW);
      chk_word($sformatf("tbl%0d", v), 0, tbl[v].exp);
      chk_word($sformatf("tbl%0d", v), 1, tbl[v].exp);
    end

    // Test pattern raised two cycles before a load edge, dropped mid-word.
    data_in = DA;
    tp_en   = 1'b0;
    ch_en   = 4'hF;
    pol_inv = 4'h0;
    sync_load(1'b0);
    fork
      cap(3 * DW);
      begin
        repeat (3) @(posedge clk_5x);
        #3 tp_en = 1'b1;
        repeat (4) @(posedge clk_5x);
        #3 tp_en = 1'b0;
      end
    join
    chk_word("tp", 0, DA);
    chk_word("tp", 1, {4{10'h3E0}});
    chk_word("tp", 2, DA);

    // Enable mask and polarity changed mid-word.
    sync_load(1'b0);
    fork
      cap(2 * DW);
      begin
        repeat (2) @(posedge clk_5x);
        #3;
        ch_en   = 4'b1011;
        pol_inv = 4'b0001;
      end
    join
    chk_word("enpol", 0, DA);
    chk_word("enpol", 1, {10'h001, 10'h000, 10'h155, 10'h0B1});

    // Reset at cnt = 2.
    data_in = DB;
    ch_en   = 4'hF;
    pol_inv = 4'h0;
    sync_load(1'b0);
    repeat (2) @(posedge clk_5x);
    #3 sys_rst_n = 1'b0;
    #1 chk("mid stb", load_stb, 0);
    @(negedge clk_5x);
    #1 chk_idle("mid neg");
    @(posedge clk_5x);
    #1 chk_idle("mid pos");
    @(negedge clk_5x);
    #1;
    release_check("mid rel", 5);
    @(posedge clk_5x);
    cap(DW);
    chk_word("mid first", 0, DB);

    // 14-bit, 2-channel instance.
    data14 = {14'h2C3D, 14'h1A5B};
    tp14   = 1'b0;
    en14   = 2'b11;
    pol14  = 2'b00;
    sync_load(1'b1);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk_5x);
      chk($sformatf("w14 stb c%0d", c), stb14, (c % 7) == 0);
    end
    @(posedge clk_5x);
    cap(2 * DW2);
    chk_word14("w14", 0, {14'h2C3D, 14'h1A5B});
    chk_word14("w14", 1, {14'h2C3D, 14'h1A5B});

    tp14  = 1'b1;
    pol14 = 2'b01;
    sync_load(1'b1);
    cap(DW2);
    chk_word14("w14tp", 0, {TP14, 14'h007F});

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end

endmodule
